rom_bus_ctrl: RTL

Z80-side memory bus controller for the 16 KB system ROM, built from two 8 KB synchronous pROM banks on the shared tri-state data bus. It decodes CPU memory-read cycles in 0x0000–0x3FFF and selects bank 0 or bank 1. It drives each bank's 13-bit address, `ce` and `oce`, and holds the CPU in wait states until registered ROM data is valid on the bus. It sits directly upstream of both 8 KB ROM wrapper instances, between the CPU bus pins and the ROM banks.

---
 rtl/rom_bus_pkg.sv | 8 +
 rtl/rom_bus_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/rom_bus_pkg.sv
// rom_bus_pkg: shared states and address map for the system ROM bus controller
package rom_bus_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRIVE, RECOVER} state_t;
    localparam logic [15:0] ROM_BASE = 16'h0000;
    localparam logic [15:0] ROM_SIZE = 16'h4000;
    localparam logic [13:0] BANK_SIZE = 14'h2000;
    localparam int ROM_AW = 13;
endpackage

// File: rtl/rom_bus_ctrl.sv
// rom_bus_ctrl: decodes Z80 reads of the 16 KB ROM and sequences two 8 KB pROM banks with wait states
module rom_bus_ctrl
    import rom_bus_pkg::*;
#(
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rom_en,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    output logic              cpu_wait_n,
    output logic [ROM_AW-1:0] rom_ad,
    output logic              rom_ce0,
    output logic              rom_oce0,
    output logic              rom_ce1,
    output logic              rom_oce1,
    output logic              busy
);
    state_t            state, nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ROM_AW-1:0] ad_nxt;
    logic              bank, bank_nxt;
    logic              req, rel, act;
    assign req = rom_en && !cpu_mreq_n && !cpu_rd_n && (cpu_addr[15:14] == 2'b00);
    assign rel = cpu_rd_n || cpu_mreq_n;
    always_comb begin
        nxt = state;
        cnt_nxt = cnt;
        ad_nxt = rom_ad;
        bank_nxt = bank;
        case (state)
            IDLE: if (req) begin
                nxt = FETCH;
                cnt_nxt = 3'(ROM_LATENCY - 1);
                ad_nxt = cpu_addr[ROM_AW-1:0];
                bank_nxt = cpu_addr[ROM_AW];
            end
            FETCH: begin
                nxt = rel ? RECOVER : (cnt == 3'd0) ? DRIVE : FETCH;
                cnt_nxt = (rel || cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
            end
            DRIVE: nxt = rel ? RECOVER : DRIVE;
            default: nxt = IDLE;
        endcase
    end
    // wait is registered from the next state so it changes together with the enables
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 3'd0;
            rom_ad <= '0;
            bank <= 1'b0;
            cpu_wait_n <= 1'b1;
        end else begin
            state <= nxt;
            cnt <= cnt_nxt;
            rom_ad <= ad_nxt;
            bank <= bank_nxt;
            cpu_wait_n <= (nxt != FETCH);
        end
    end
    assign act = (state == FETCH) || (state == DRIVE);
    assign rom_ce0 = act && !bank;
    assign rom_ce1 = act && bank;
    assign rom_oce0 = (state == DRIVE) && !bank;
    assign rom_oce1 = (state == DRIVE) && bank;
    assign busy = (state != IDLE);
endmodule
